// File: rtl/ov7670_stream_gen.sv
// ============================================================================
// ov7670_stream_gen : OV7670-style RGB565 pixel-stream source (test patterns)
// Revision          : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ov7670_stream_gen #(
  parameter int CAM_SCREEN_X = 320,
  parameter int CAM_SCREEN_Y = 240,
  parameter int VSYNC_LEN    = 16,
  parameter int V_BACK       = 32,
  parameter int H_BLANK      = 144,
  parameter int V_FRONT      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  px_data,
  output logic        frame_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_VBACK  = 3'd2,
    S_LINE   = 3'd3,
    S_HBLANK = 3'd4,
    S_VFRONT = 3'd5
  } state_t;

  localparam logic [15:0] c_vsync_last  = 16'(VSYNC_LEN - 1);
  localparam logic [15:0] c_vback_last  = 16'(V_BACK - 1);
  localparam logic [15:0] c_line_last   = 16'(2 * CAM_SCREEN_X - 1);
  localparam logic [15:0] c_hblank_last = 16'(H_BLANK - 1);
  localparam logic [15:0] c_vfront_last = 16'(V_FRONT - 1);
  localparam logic [15:0] c_x_last      = 16'(CAM_SCREEN_X - 1);
  localparam logic [15:0] c_y_count     = 16'(CAM_SCREEN_Y);
  localparam logic [15:0] c_bar_last    = 16'(CAM_SCREEN_X / 8 - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic [15:0] bar_cnt_q, bar_cnt_d;
  logic [15:0] pix_idx_q, pix_idx_d;
  logic [1:0]  mode_q, mode_d;
  logic [15:0] solid_q, solid_d;
  logic        pclk_q, pclk_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  px_data_q, px_data_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;
  logic        start_frame;
  logic [15:0] pix_val;

  // Pixel counters always point at the next pixel to be launched.
  always_comb begin
    pix_val = 16'h0000;
    unique case (mode_q)
      2'd0: begin
        unique case (bar_idx_q)
          3'd0: pix_val = 16'hFFFF;
          3'd1: pix_val = 16'hFFE0;
          3'd2: pix_val = 16'h07FF;
          3'd3: pix_val = 16'h07E0;
          3'd4: pix_val = 16'hF81F;
          3'd5: pix_val = 16'hF800;
          3'd6: pix_val = 16'h001F;
          3'd7: pix_val = 16'h0000;
        endcase
      end
      2'd1: pix_val = solid_q;
      2'd2: pix_val = {x_q[8:4], y_q[7:2], 5'b00000};
      2'd3: pix_val = pix_idx_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    x_d          = x_q;
    y_d          = y_q;
    bar_idx_d    = bar_idx_q;
    bar_cnt_d    = bar_cnt_q;
    pix_idx_d    = pix_idx_q;
    mode_d       = mode_q;
    solid_d      = solid_q;
    pclk_d       = ~pclk_q;
    vsync_d      = vsync_q;
    href_d       = href_q;
    px_data_d    = px_data_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    start_frame  = 1'b0;

    if (!pclk_q) begin
      // Raised one clk ahead of the falling edge that leaves VFRONT.
      frame_done_d = (state_q == S_VFRONT) && (cnt_q == c_vfront_last);
    end else begin
      cnt_d = cnt_q + 16'd1;
      case (state_q)
        S_IDLE: begin
          cnt_d       = 16'd0;
          start_frame = enable;
        end
        S_VSYNC: if (cnt_q == c_vsync_last) begin
          state_d = S_VBACK;
          cnt_d   = 16'd0;
        end
        S_VBACK: if (cnt_q == c_vback_last) begin
          state_d = S_LINE;
          cnt_d   = 16'd0;
        end
        S_LINE: if (cnt_q == c_line_last) begin
          state_d = S_HBLANK;
          cnt_d   = 16'd0;
        end
        S_HBLANK: if (cnt_q == c_hblank_last) begin
          state_d = (y_q == c_y_count) ? S_VFRONT : S_LINE;
          cnt_d   = 16'd0;
        end
        S_VFRONT: if (cnt_q == c_vfront_last) begin
          state_d     = S_IDLE;
          cnt_d       = 16'd0;
          start_frame = enable;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end
      endcase

      if (start_frame) begin
        state_d   = S_VSYNC;
        mode_d    = mode;
        solid_d   = solid_color;
        x_d       = 16'd0;
        y_d       = 16'd0;
        bar_idx_d = 3'd0;
        bar_cnt_d = 16'd0;
        pix_idx_d = 16'd0;
      end

      vsync_d   = (state_d == S_VSYNC);
      href_d    = (state_d == S_LINE);
      busy_d    = (state_d != S_IDLE);
      px_data_d = 8'h00;
      if (state_d == S_LINE) begin
        if (!cnt_d[0]) begin
          px_data_d = pix_val[15:8];
        end else begin
          // Low byte closes the pixel: advance every pixel counter.
          px_data_d = pix_val[7:0];
          pix_idx_d = pix_idx_q + 16'd1;
          if (x_q == c_x_last) begin
            x_d = 16'd0;
            y_d = y_q + 16'd1;
          end else begin
            x_d = x_q + 16'd1;
          end
          if (bar_cnt_q == c_bar_last) begin
            bar_cnt_d = 16'd0;
            bar_idx_d = bar_idx_q + 3'd1;
          end else begin
            bar_cnt_d = bar_cnt_q + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 16'd0;
      x_q          <= 16'd0;
      y_q          <= 16'd0;
      bar_idx_q    <= 3'd0;
      bar_cnt_q    <= 16'd0;
      pix_idx_q    <= 16'd0;
      mode_q       <= 2'd0;
      solid_q      <= 16'd0;
      pclk_q       <= 1'b0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      px_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      x_q          <= x_d;
      y_q          <= y_d;
      bar_idx_q    <= bar_idx_d;
      bar_cnt_q    <= bar_cnt_d;
      pix_idx_q    <= pix_idx_d;
      mode_q       <= mode_d;
      solid_q      <= solid_d;
      pclk_q       <= pclk_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      px_data_q    <= px_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign pclk       = pclk_q;
  assign vsync      = vsync_q;
  assign href       = href_q;
  assign px_data    = px_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ov7670_stream_gen.sv
// ============================================================================
// tb_ov7670_stream_gen : scoreboard bench for the OV7670-style stream source
// Revision             : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ov7670_stream_gen;

  localparam int X  = 8;
  localparam int Y  = 4;
  localparam int VS = 3;
  localparam int VB = 2;
  localparam int HB = 4;
  localparam int VF = 2;
  localparam int FRAME_CLK = 2 * (VS + VB + Y * (2 * X + HB) + VF);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_color = 16'h0000;
  logic        pclk, vsync, href, frame_done, busy;
  logic [7:0]  px_data;

  ov7670_stream_gen #(
    .CAM_SCREEN_X(X), .CAM_SCREEN_Y(Y), .VSYNC_LEN(VS),
    .V_BACK(VB), .H_BLANK(HB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .solid_color(solid_color), .pclk(pclk), .vsync(vsync), .href(href),
    .px_data(px_data), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int frames_seen = 0;
  int frames_pushed = 0;
  logic [7:0] exp_q[$];
  bit sb_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Reference pattern computed straight from the pattern definitions.
  function automatic logic [15:0] ref_pix(input int m, input logic [15:0] s, input int x, input int y);
    logic [15:0] bars [8];
    logic [15:0] xv, yv;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    xv = 16'(x);
    yv = 16'(y);
    case (m)
      0: return bars[x / (X / 8)];
      1: return s;
      2: return {xv[8:4], yv[7:2], 5'b00000};
      default: return 16'((y * X + x) % 65536);
    endcase
  endfunction

  task automatic push_frame(input int m, input logic [15:0] s);
    logic [15:0] p;
    for (int yy = 0; yy < Y; yy++) begin
      for (int xx = 0; xx < X; xx++) begin
        p = ref_pix(m, s, xx, yy);
        exp_q.push_back(p[15:8]);
        exp_q.push_back(p[7:0]);
      end
    end
    frames_pushed++;
  endtask

  // Monitor: bytes on pclk rising, plus frame timing.
  logic prev_pclk, prev_vsync, prev_href;
  bit   done_pending;
  bit   exp_next;
  int   frame_cyc, vs_len, href_len, low_len, lines;

  always @(negedge clk) begin
    if (!sb_on) begin
      frame_cyc = 0; vs_len = 0; href_len = 0; low_len = 0; lines = 0;
      done_pending = 1'b0;
    end else begin
      frame_cyc++;
      check("pclk_toggle", {31'd0, pclk}, {31'd0, ~prev_pclk});
      if (done_pending) begin
        check("vsync_after_done", {31'd0, vsync}, {31'd0, exp_next});
        check("busy_after_done", {31'd0, busy}, {31'd0, exp_next});
        done_pending = 1'b0;
      end
      if (vsync && !prev_vsync) begin
        frame_cyc = 0; lines = 0; vs_len = 0;
        frames_seen++;
      end
      if (!vsync && prev_vsync) begin
        check("vsync_len", vs_len, 2 * VS);
        low_len = 0;
      end
      if (href && !prev_href) begin
        if (lines == 0) check("vback_gap", low_len, 2 * VB);
        else            check("hblank_gap", low_len, 2 * HB);
        href_len = 0;
      end
      if (!href && prev_href) begin
        check("href_len", href_len, 2 * 2 * X);
        lines++;
        low_len = 0;
      end
      if (vsync) vs_len++;
      if (href) href_len++; else low_len++;
      if (pclk && !prev_pclk) begin
        if (href) begin
          if (exp_q.size() == 0) fail_now("sb_underflow");
          else check("px_byte", px_data, exp_q.pop_front());
        end else begin
          check("px_zero_blank", px_data, 0);
        end
      end
      if (frame_done) begin
        check("done_cycle", frame_cyc, FRAME_CLK - 1);
        check("done_lines", lines, Y);
        check("done_busy", {31'd0, busy}, 1);
        done_pending = 1'b1;
        exp_next = enable;
      end
    end
    prev_pclk = pclk; prev_vsync = vsync; prev_href = href;
  end

  task automatic wait_vsync(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      @(posedge clk); #1;
      if (vsync) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("vsync_wait");
  endtask

  task automatic wait_busy_low();
    bit ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      @(posedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("busy_low_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int cm [6];
  logic [15:0] cs [6];

  initial begin
    bit ok;
    // Reset held: all outputs low.
    #2;
    check("rst_pclk", {31'd0, pclk}, 0);
    check("rst_vsync", {31'd0, vsync}, 0);
    check("rst_href", {31'd0, href}, 0);
    check("rst_px", px_data, 0);
    check("rst_done", {31'd0, frame_done}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("pclk_first_high", {31'd0, pclk}, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_pclk", {31'd0, pclk}, {31'd0, i[0]});
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_vsync", {31'd0, vsync}, 0);
    end

    // Asynchronous reset in the middle of a line.
    mode = 2'd1; solid_color = 16'h5A5A; enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_CLK; i++) begin
      @(posedge clk); #1;
      if (href) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("href_wait");
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("midrst_pclk", {31'd0, pclk}, 0);
    check("midrst_vsync", {31'd0, vsync}, 0);
    check("midrst_href", {31'd0, href}, 0);
    check("midrst_px", px_data, 0);
    check("midrst_done", {31'd0, frame_done}, 0);
    check("midrst_busy", {31'd0, busy}, 0);
    enable = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    @(posedge clk); #1;
    sb_on = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Single colour-bar frame, enable pulsed.
    mode = 2'd0;
    push_frame(0, 16'h0000);
    enable = 1'b1;
    wait_vsync(ok);
    enable = 1'b0;
    wait_busy_low();
    repeat (20) @(posedge clk);
    #1;

    // Back-to-back frames, next configuration applied mid-frame.
    cm = '{1, 1, 3, 3, 0, 0};
    cs = '{16'h1234, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int k = 4; k < 6; k++) begin
      cm[k] = int'($urandom_range(0, 3));
      cs[k] = 16'($urandom);
    end
    mode = 2'(cm[0]); solid_color = cs[0];
    push_frame(cm[0], cs[0]);
    enable = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_vsync(ok);
      if (!ok) break;
      repeat ($urandom_range(10, 140)) @(posedge clk);
      #1;
      if (k < 5) begin
        mode = 2'(cm[k + 1]); solid_color = cs[k + 1];
        push_frame(cm[k + 1], cs[k + 1]);
      end else begin
        enable = 1'b0;
      end
    end
    wait_busy_low();
    repeat (20) @(posedge clk);
    #1;
    check("idle_busy_end", {31'd0, busy}, 0);
    check("sb_empty", exp_q.size(), 0);
    check("frame_count", frames_seen, frames_pushed);
    sb_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
